// File: rtl/mem_port_arbiter.sv
// Shares one single-port word RAM between instruction fetch and load/store.
// Loads get lane extraction. Sub-word stores use read-modify-write.
// Optional: define MEM_MISALIGN_TRAP_EN to add d_err and trap misaligned accesses.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_BITS  = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [WIDTH-1:0]     i_addr,
    output logic                 i_ready,
    output logic                 i_rvalid,
    output logic [WIDTH-1:0]     i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WIDTH-1:0]     d_addr,
    input  logic [WIDTH-1:0]     d_wdata,
    input  logic [2:0]           d_funct3,
    output logic                 d_ready,
    output logic                 d_rvalid,
    output logic [WIDTH-1:0]     d_rdata,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_wren,
    output logic [WIDTH-1:0]     ram_data,
    input  logic [WIDTH-1:0]     ram_q
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                 d_err
`endif
);
    localparam logic [2:0] FN_B  = 3'b000;
    localparam logic [2:0] FN_H  = 3'b001;
    localparam logic [2:0] FN_BU = 3'b100;
    localparam logic [2:0] FN_HU = 3'b101;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, RD, RMW} state_t;

    state_t               state, state_nx;
    logic [3:0]           starve;
    logic                 fetch_win, can_accept, i_acc, d_acc;
    logic                 sz_b, sz_h, sz_w, mis;
    logic [WIDTH-1:0]     i_hold, d_hold, d_ext;
    logic                 unused_bits;

    logic                 src_fetch_p1;
    logic [2:0]           fn_p1;
    logic [1:0]           lane_p1;
    logic [ADDR_BITS-1:0] waddr_p1;
    logic [15:0]          wdata_p1;

    function automatic logic [WIDTH-1:0] load_ext(input logic [WIDTH-1:0] q,
                                                  input logic [2:0] fn,
                                                  input logic [1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = q[{lane, 3'b000} +: 8];
        h = q[{lane[1], 4'b0000} +: 16];
        case (fn)
            FN_B:    load_ext = {{(WIDTH-8){b[7]}}, b};
            FN_BU:   load_ext = {{(WIDTH-8){1'b0}}, b};
            FN_H:    load_ext = {{(WIDTH-16){h[15]}}, h};
            FN_HU:   load_ext = {{(WIDTH-16){1'b0}}, h};
            default: load_ext = q;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] q,
                                                     input logic [2:0] fn,
                                                     input logic [1:0] lane,
                                                     input logic [15:0] wd);
        store_merge = q;
        if (fn == FN_B)
            store_merge[{lane, 3'b000} +: 8] = wd[7:0];
        else
            store_merge[{lane[1], 4'b0000} +: 16] = wd;
    endfunction

    // Data port wins unless it is idle or fetch has been refused STARVE_MAX times.
    assign can_accept = rst && (state != RMW);
    assign fetch_win  = i_req && (!d_req || (starve == STARVE_LIM));
    assign i_ready    = can_accept && fetch_win;
    assign d_ready    = can_accept && !fetch_win;
    assign i_acc      = i_req && i_ready;
    assign d_acc      = d_req && d_ready;

    assign sz_b = d_we ? (d_funct3 == FN_B) : (d_funct3 == FN_B || d_funct3 == FN_BU);
    assign sz_h = d_we ? (d_funct3 == FN_H) : (d_funct3 == FN_H || d_funct3 == FN_HU);
    assign sz_w = !sz_b && !sz_h;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = (sz_h && d_addr[0]) || (sz_w && (d_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign d_ext    = load_ext(ram_q, fn_p1, lane_p1);
    assign i_rvalid = (state == RD) && src_fetch_p1;
    assign d_rvalid = (state == RD) && !src_fetch_p1;
    assign i_rdata  = i_rvalid ? ram_q : i_hold;
    assign d_rdata  = d_rvalid ? d_ext : d_hold;

    assign unused_bits = ^{i_addr[WIDTH-1:ADDR_BITS+2], i_addr[1:0],
                           d_addr[WIDTH-1:ADDR_BITS+2]};

    always_comb begin
        state_nx = state;
        ram_addr = '0;
        ram_wren = 1'b0;
        ram_data = '0;
        case (state)
            RMW: begin
                ram_addr = waddr_p1;
                ram_wren = 1'b1;
                ram_data = store_merge(ram_q, fn_p1, lane_p1, wdata_p1);
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                if (i_acc) begin
                    ram_addr = i_addr[ADDR_BITS+1:2];
                    state_nx = RD;
                end else if (d_acc) begin
                    ram_addr = d_addr[ADDR_BITS+1:2];
                    if (mis)
                        state_nx = IDLE;
                    else if (!d_we)
                        state_nx = RD;
                    else if (sz_w) begin
                        ram_wren = 1'b1;
                        ram_data = d_wdata;
                    end else
                        state_nx = RMW;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            starve <= '0;
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            state <= state_nx;
            if (i_req && !i_ready) begin
                if (starve != STARVE_LIM)
                    starve <= starve + 4'd1;
            end else
                starve <= '0;
            if (state == RD) begin
                if (src_fetch_p1)
                    i_hold <= ram_q;
                else
                    d_hold <= d_ext;
            end
            if (d_acc && mis && !d_we)
                d_hold <= '0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            d_err <= 1'b0;
        else
            d_err <= d_acc && mis;
    end
`endif

    // p1: accepted request captured for the RD response or the RMW write
    always_ff @(posedge clk) begin
        if (i_acc || d_acc) begin
            src_fetch_p1 <= i_acc;
            fn_p1        <= d_funct3;
            lane_p1      <= d_addr[1:0];
            waddr_p1     <= d_addr[ADDR_BITS+1:2];
            wdata_p1     <= d_wdata[15:0];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_funct3 = 3'b010;
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic [11:0] ram_addr;
    logic        ram_wren;
    logic [31:0] ram_data;
    logic [31:0] ram_q;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        d_err;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q)
`ifdef MEM_MISALIGN_TRAP_EN
        , .d_err(d_err)
`endif
    );

    typedef struct {
        logic        we;
        logic [2:0]  fn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic data_op(input logic we, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        d_req = 1'b1; d_we = we; d_funct3 = fn; d_addr = a; d_wdata = wd;
        @(negedge clk);
        while (!d_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!d_ready) begin
            tests++;
            fails++;
            $display("FAIL d_ready timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_exp;
        logic        prev_i, prev_d;
        int          both;

        // reset state
        @(negedge clk);
        check("rst i_ready", 32'(i_ready), 32'd0);
        check("rst d_ready", 32'(d_ready), 32'd0);
        check("rst rvalids", 32'({i_rvalid, d_rvalid}), 32'd0);
        check("rst ram_wren", 32'(ram_wren), 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst d_err", 32'(d_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // SW then LW back to back
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("sw d_ready", 32'(d_ready), 32'd1);
        check("sw ram_wren", 32'(ram_wren), 32'd1);
        check("sw ram_data", ram_data, 32'hDEADBEEF);
        check("sw ram_addr", 32'(ram_addr), 32'h40);
        @(posedge clk); #1;
        d_we = 1'b0;
        @(negedge clk);
        check("lw d_ready", 32'(d_ready), 32'd1);
        check("sw wren one cycle", 32'(ram_wren), 32'd0);
        check("lw no early rvalid", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("lw rvalid", 32'(d_rvalid), 32'd1);
        check("lw rdata", d_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // SB read-modify-write with a load queued behind it
        data_op(1'b1, 3'b010, 32'h104, 32'h11223344);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h105; d_wdata = 32'h0000005A;
        @(negedge clk);
        check("sb d_ready", 32'(d_ready), 32'd1);
        check("sb no wren in read", 32'(ram_wren), 32'd0);
        @(posedge clk); #1;
        d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h104;
        @(negedge clk);
        check("rmw d_ready low", 32'(d_ready), 32'd0);
        check("rmw ram_wren", 32'(ram_wren), 32'd1);
        check("rmw ram_data", ram_data, 32'h11225A44);
        check("rmw ram_addr", 32'(ram_addr), 32'h41);
        check("rmw no rvalid", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post rmw d_ready", 32'(d_ready), 32'd1);
        check("post rmw wren", 32'(ram_wren), 32'd0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("lw after sb", d_rdata, 32'h11225A44);
        @(posedge clk); #1;

        // table-driven loads and stores
        vecs.push_back('{1'b1, 3'b010, 32'h108, 32'h80FF7F01, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h10B, 32'h0, 32'hFFFFFF80});
        vecs.push_back('{1'b0, 3'b100, 32'h10B, 32'h0, 32'h00000080});
        vecs.push_back('{1'b0, 3'b001, 32'h10A, 32'h0, 32'hFFFF80FF});
        vecs.push_back('{1'b0, 3'b101, 32'h10A, 32'h0, 32'h000080FF});
        vecs.push_back('{1'b0, 3'b000, 32'h108, 32'h0, 32'h00000001});
        vecs.push_back('{1'b0, 3'b000, 32'h109, 32'h0, 32'h0000007F});
        vecs.push_back('{1'b0, 3'b000, 32'h10A, 32'h0, 32'hFFFFFFFF});
        vecs.push_back('{1'b0, 3'b100, 32'h10A, 32'h0, 32'h000000FF});
        vecs.push_back('{1'b0, 3'b001, 32'h108, 32'h0, 32'h00007F01});
        vecs.push_back('{1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{1'b1, 3'b001, 32'h10E, 32'h00001234, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h10C, 32'h0, 32'h1234F00D});
        vecs.push_back('{1'b1, 3'b001, 32'h10C, 32'hFFFF9876, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h10C, 32'h0, 32'h12349876});
        vecs.push_back('{1'b1, 3'b010, 32'h110, 32'h00000000, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h112, 32'hFFFFFFA5, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h110, 32'h0, 32'h00A50000});
        vecs.push_back('{1'b0, 3'b011, 32'h104, 32'h0, 32'h11225A44});
        vecs.push_back('{1'b0, 3'b010, 32'h00004104, 32'h0, 32'h11225A44});
`ifndef MEM_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 3'b001, 32'h109, 32'h0, 32'h00007F01});
        vecs.push_back('{1'b0, 3'b010, 32'h10A, 32'h0, 32'h80FF7F01});
`endif
        last_exp = '0;
        foreach (vecs[k]) begin
            data_op(vecs[k].we, vecs[k].fn, vecs[k].addr, vecs[k].wdata);
            if (!vecs[k].we) begin
                @(negedge clk);
                check($sformatf("vec%0d rvalid", k), 32'(d_rvalid), 32'd1);
                check($sformatf("vec%0d rdata", k), d_rdata, vecs[k].exp);
                last_exp = vecs[k].exp;
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        @(negedge clk);
        check("rdata held", d_rdata, last_exp);
        check("rvalid idle", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;

        // fetch alone wins immediately
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        check("fetch only ready", 32'(i_ready), 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        check("fetch rvalid", 32'(i_rvalid), 32'd1);
        check("fetch rdata", i_rdata, 32'hDEADBEEF);
        check("fetch no d_rvalid", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;

        // both ports saturating: fetch granted every STARVE_MAX+1 cycles
        i_req = 1'b1; i_addr = 32'h108;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h104;
        both = 0; prev_i = 1'b0; prev_d = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (i_ready && d_ready) both++;
            check($sformatf("starve c%0d i_ready", c), 32'(i_ready), 32'((c % 5) == 4));
            if (prev_i) check($sformatf("starve c%0d i_rdata", c),
                              i_rvalid ? i_rdata : 32'hX, 32'h80FF7F01);
            if (prev_d) check($sformatf("starve c%0d d_rdata", c),
                              d_rvalid ? d_rdata : 32'hX, 32'h11225A44);
            prev_i = i_ready;
            prev_d = d_ready;
        end
        check("both readys high", 32'(both), 32'd0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // reset asserted during the RMW cycle of SH
        data_op(1'b1, 3'b010, 32'h200, 32'h55667788);
        data_op(1'b1, 3'b001, 32'h200, 32'h0000AAAA);
        check("sh rmw wren", 32'(ram_wren), 32'd1);
        i_req = 1'b1;
        rst = 1'b0;
        #1;
        check("rst wren drop", 32'(ram_wren), 32'd0);
        check("rst readys", 32'({i_ready, d_ready}), 32'd0);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        check("rst ram_data", ram_data, 32'd0);
        check("rst i_rdata", i_rdata, 32'd0);
        check("rst d_rdata mid", d_rdata, 32'd0);
        @(negedge clk);
        check("rst held readys", 32'({i_ready, d_ready, i_rvalid, d_rvalid, ram_wren}), 32'd0);
        i_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        data_op(1'b0, 3'b010, 32'h200, 32'h0);
        @(negedge clk);
        check("word after aborted sh", d_rdata, 32'h55667788);
        @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
        data_op(1'b0, 3'b010, 32'h102, 32'h0);
        @(negedge clk);
        check("mis lw d_err", 32'(d_err), 32'd1);
        check("mis lw rvalid", 32'(d_rvalid), 32'd0);
        check("mis lw rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("d_err one cycle", 32'(d_err), 32'd0);
        @(posedge clk); #1;
        data_op(1'b1, 3'b001, 32'h201, 32'h0000BBBB);
        @(negedge clk);
        check("mis sh d_err", 32'(d_err), 32'd1);
        check("mis sh no wren", 32'(ram_wren), 32'd0);
        @(posedge clk); #1;
        data_op(1'b0, 3'b010, 32'h200, 32'h0);
        @(negedge clk);
        check("mis sh mem unchanged", d_rdata, 32'h55667788);
        check("aligned lw no d_err", 32'(d_err), 32'd0);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous word RAM between the instruction-fetch port and the load/store data port of the RISC-V core.
- Performs byte-lane extraction with sign/zero extension on loads.
- Performs read-modify-write for byte and halfword stores, because the RAM has no byte enables.
- Sits between the core's fetch/LSU stages and the RAM instance; replaces direct RAM hookup from the memory stage.

Parameters:
- WIDTH, 32, data and byte-address width.
- ADDR_BITS, 12, RAM word-address width; ram_addr = addr[ADDR_BITS+1:2], higher address bits ignored.
- STARVE_MAX, 4, consecutive cycles fetch may be refused before it is forced to win arbitration (1..15).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  WIDTH  fetch byte address; bits [1:0] ignored.
- i_ready  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  WIDTH  fetched word.
- d_req  in  1  data request.
- d_we  in  1  0 = load, 1 = store.
- d_addr  in  WIDTH  data byte address.
- d_wdata  in  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- d_funct3  in  funct3_t (LOAD_STORE_FNS)  000 B, 001 H, 010 W, 100 BU, 101 HU.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  WIDTH  extended load result.
- ram_addr  out  ADDR_BITS  to ram.address.
- ram_wren  out  1  to ram.wren.
- ram_data  out  WIDTH  to ram.data.
- ram_q  in  WIDTH  from ram.q; valid one cycle after address is presented.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, starve counter = 0.
  - i_rvalid, d_rvalid, ram_wren = 0; i_rdata, d_rdata = 0.
  - i_ready, d_ready = 0 while rst is low.
- Handshake: a request is accepted when req && ready are high in the same cycle. Ready is combinational and depends only on state, the other port's req, and the starve counter. Requesters hold address and data until accepted.
- Arbitration, in IDLE or RD:
  - Only one of i_ready/d_ready may be high in a cycle.
  - Data port wins by default.
  - Fetch wins if only fetch requests, or if starve counter == STARVE_MAX.
  - Starve counter increments each cycle i_req is high and refused; it clears when fetch is accepted or i_req is low; it saturates at STARVE_MAX.
- States: IDLE, RD, RMW.
  - IDLE/RD + accepted load, fetch, or word store: drive ram_addr from the request in the same cycle.
    - Word store: ram_wren = 1, ram_data = d_wdata; next state IDLE.
    - Load or fetch: next state RD.
  - RD: ram_q is valid. Assert the matching rvalid with data this cycle; rdata is registered and held until the next response. A new request may be accepted in the same cycle, giving back-to-back reads at 1 per cycle with latency 1.
  - IDLE/RD + accepted SB/SH: issue a read of the word; next state RMW.
  - RMW:
    - Both readys = 0.
    - ram_addr = latched word address, ram_wren = 1.
    - ram_data = ram_q with the addressed lane replaced by the latched d_wdata byte or half.
    - Next state IDLE.
    - SB/SH therefore take 2 cycles; stores never assert d_rvalid.
- Load lanes:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes ram_q.
  - Undefined funct3 is treated as W.
- Misaligned access (feature off): H/HU/SH with addr[0] = 1 use lane addr[1]; W ignores addr[1:0].
- Reset during RMW: the write is abandoned; ram_wren falls immediately and memory is unchanged.
- Simultaneous requests with the counter at STARVE_MAX: fetch wins; data stays pending and is served next cycle.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port d_err (1 bit, reset 0).
  - An accepted H/HU/SH with addr[0] = 1, or W with addr[1:0] != 0, asserts d_err for one cycle at the time d_rvalid would have been asserted (next cycle).
  - For misaligned loads, d_rdata = 0 and d_rvalid = 0.
  - For misaligned stores, no RAM write occurs.
- When undefined: no d_err port; misaligned behaviour as above.

Test Plan:
- SW 0xDEADBEEF to 0x100, then LW 0x100 -> d_rvalid 2 cycles after SW acceptance (1 after LW) with d_rdata 0xDEADBEEF; ram_wren high exactly 1 cycle.
- SB 0x5A to 0x101 over 0x11223344 -> 2-cycle store with d_ready low in RMW; LW returns 0x11225A44.
- LB/LBU at 0x103 of 0x80FF7F01 -> 0xFFFFFF80 / 0x00000080; LH/LHU at 0x102 -> 0xFFFF80FF / 0x000080FF.
- i_req and d_req held high continuously with back-to-back loads -> fetch granted exactly once every STARVE_MAX+1 cycles (every 5th cycle at default); no cycle with both readys high.
- rst pulled low in the RMW cycle of SH to 0x200 -> ram_wren drops asynchronously; word 0x200 unchanged; all outputs 0 until release.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> d_err = 1 next cycle, d_rvalid = 0; SH at 0x201 -> d_err = 1, memory unchanged.
